// File: rtl/note_seq_pkg.sv
// Shared types for the note sequencer: FSM state encoding and note RAM entry layout.
// An entry is {period, duration}, with the period in the upper bits.
package note_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_t;

  localparam int DEF_COUNTER_WIDTH = 8;
  localparam int DEF_DUR_WIDTH     = 8;
  localparam int ENTRY_WIDTH       = DEF_COUNTER_WIDTH + DEF_DUR_WIDTH;

  function automatic int entry_width(input int counter_width, input int dur_width);
    return counter_width + dur_width;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Host-side bundle of the note sequencer: RAM write port, playback control and playback outputs.
// Handshakes: wr_en is a valid with an implicit always-ready (every write is taken
// the cycle it is presented); start is a level request taken only while busy is low;
// stop is taken in any non-idle state.
interface note_sequencer_if #(
  parameter int COUNTER_WIDTH = 8,
  parameter int DUR_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 4
);
  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [COUNTER_WIDTH-1:0] wr_period;
  logic [DUR_WIDTH-1:0]     wr_dur;
  logic                     start;
  logic                     stop;
  logic                     loop;
  logic [ADDR_WIDTH-1:0]    last_addr;
  logic [COUNTER_WIDTH-1:0] freq_out;
  logic                     note_on;
  logic                     busy;
  logic                     done;
  logic [ADDR_WIDTH-1:0]    cur_addr;

  modport master (
    output wr_en, wr_addr, wr_period, wr_dur, start, stop, loop, last_addr,
    input  freq_out, note_on, busy, done, cur_addr
  );

  modport slave (
    input  wr_en, wr_addr, wr_period, wr_dur, start, stop, loop, last_addr,
    output freq_out, note_on, busy, done, cur_addr
  );
endinterface

// File: rtl/tick_divider.sv
// Duration-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
module tick_divider #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap = (cnt_q == CW'(TICK_DIV - 1));
  assign tick = en && wrap;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: steps a (period, duration) note RAM and drives the square-wave
// generator period plus an audio gate, with an optional articulation gap per note.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int DUR_WIDTH     = DEF_DUR_WIDTH,
  parameter int ADDR_WIDTH    = 4,
  parameter int TICK_DIV      = 1000,
  parameter int GAP_TICKS     = 1
) (
  input  logic              clk,
  input  logic              reset,
  note_sequencer_if.slave   bus,
  output seq_state_t        state_dbg
);
  localparam int EW    = entry_width(COUNTER_WIDTH, DUR_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int GW    = $clog2(GAP_TICKS + 2);

  logic [EW-1:0] ram [DEPTH];

  seq_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]    last_q;
  logic [DUR_WIDTH-1:0]     remain_q;
  logic [GW-1:0]            gap_q;
  logic [COUNTER_WIDTH-1:0] freq_q;
  logic                     note_q;
  logic                     done_q;

  logic                     tick;
  logic                     launch;
  logic                     load_note;
  logic                     enter_gap;
  logic                     finish;
  logic                     abort;
  logic                     adv;

  logic [EW-1:0]            rd_entry;
  logic [COUNTER_WIDTH-1:0] rd_period;
  logic [DUR_WIDTH-1:0]     rd_dur;

  // The FETCH-cycle read lands directly in the freq/remaining registers, so the
  // note is audible the cycle after FETCH; a same-edge write is not yet visible.
  assign rd_entry  = ram[addr_q];
  assign rd_period = rd_entry[EW-1 -: COUNTER_WIDTH];
  assign rd_dur    = rd_entry[DUR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      ram[bus.wr_addr] <= {bus.wr_period, bus.wr_dur};
    end
  end

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q == ST_IDLE) || (state_q == ST_FETCH)),
    .en    ((state_q == ST_PLAY) || (state_q == ST_GAP)),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    launch  = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    adv     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = ST_FETCH;
          addr_d  = '0;
          launch  = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_PLAY;
      ST_PLAY: begin
        if (tick && (remain_q == DUR_WIDTH'(1))) begin
          if (GAP_TICKS > 0) state_d = ST_GAP;
          else               adv     = 1'b1;
        end
      end
      ST_GAP: begin
        if (tick && (gap_q == GW'(1))) adv = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (adv) begin
      if (addr_q != last_q) begin
        addr_d  = addr_q + 1'b1;
        state_d = ST_FETCH;
      end else if (bus.loop) begin
        addr_d  = '0;
        state_d = ST_FETCH;
      end else begin
        state_d = ST_IDLE;
        finish  = 1'b1;
      end
    end

    // stop overrides any progress made this cycle and suppresses done
    if ((state_q != ST_IDLE) && bus.stop) begin
      state_d = ST_IDLE;
      addr_d  = addr_q;
      finish  = 1'b0;
      abort   = 1'b1;
    end
  end

  assign load_note = (state_q == ST_FETCH) && (state_d == ST_PLAY);
  assign enter_gap = (state_q == ST_PLAY)  && (state_d == ST_GAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      remain_q <= '0;
      gap_q    <= '0;
      freq_q   <= '0;
      note_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= finish;
      if (launch) last_q <= bus.last_addr;
      if (load_note) begin
        freq_q   <= rd_period;
        note_q   <= (rd_period != '0);
        remain_q <= (rd_dur == '0) ? DUR_WIDTH'(1) : rd_dur;
      end
      if ((state_q == ST_PLAY) && tick) remain_q <= remain_q - 1'b1;
      if ((state_q == ST_GAP) && tick)  gap_q    <= gap_q - 1'b1;
      if (enter_gap) begin
        note_q <= 1'b0;
        gap_q  <= GW'(GAP_TICKS);
      end
      if (finish || abort) begin
        freq_q <= '0;
        note_q <= 1'b0;
      end
    end
  end

  assign bus.freq_out = freq_q;
  assign bus.note_on  = note_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.cur_addr = addr_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a note-level model predicts every output change with its cycle,
// and a negedge monitor checks each observed change against that expected queue.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int CW = 8;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TD = 4;
  localparam int GT = 1;

  typedef logic [14:0] tup_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  note_sequencer_if #(.COUNTER_WIDTH(CW), .DUR_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  seq_state_t state_dbg;

  note_sequencer #(
    .COUNTER_WIDTH (CW),
    .DUR_WIDTH     (DW),
    .ADDR_WIDTH    (AW),
    .TICK_DIV      (TD),
    .GAP_TICKS     (GT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  int          mem_p [16];
  int          mem_d [16];
  tup_t        trace [$];
  int          fetch_idx [$];
  logic [46:0] exp_q [$];
  int          m_freq = 0;
  tup_t        m_last;

  function automatic tup_t mk(input int f, input bit n, input bit b, input bit d, input int a);
    return {8'(f), n, b, d, 4'(a)};
  endfunction

  task automatic add_note(input int a);
    int p, d;
    p = mem_p[a];
    d = (mem_d[a] == 0) ? 1 : mem_d[a];
    fetch_idx.push_back(trace.size());
    trace.push_back(mk(m_freq, 1'b0, 1'b1, 1'b0, a));
    repeat (d * TD) trace.push_back(mk(p, p != 0, 1'b1, 1'b0, a));
    repeat (GT * TD) trace.push_back(mk(p, 1'b0, 1'b1, 1'b0, a));
    m_freq = p;
  endtask

  task automatic add_done(input int a);
    trace.push_back(mk(0, 1'b0, 1'b0, 1'b1, a));
    trace.push_back(mk(0, 1'b0, 1'b0, 1'b0, a));
    m_freq = 0;
  endtask

  task automatic push_change(input int c, input tup_t t);
    if (t != m_last) exp_q.push_back({32'(c), t});
    m_last = t;
  endtask

  // Convert the per-cycle trace (index 0 = FETCH cycle s) into timed change events;
  // a cut index replaces the remainder of the trace by a forced idle tuple.
  task automatic commit(input int s, input int cut, input tup_t cut_t);
    for (int i = 0; i < trace.size(); i++) begin
      if (cut >= 0 && i >= cut) break;
      push_change(s + i, trace[i]);
    end
    if (cut >= 0) begin
      push_change(s + cut, cut_t);
      m_freq = 0;
    end
    trace.delete();
    fetch_idx.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit   mon_en = 1'b0;
  tup_t prev_t;

  always @(negedge clk) begin
    tup_t        cur_t;
    logic [46:0] e;
    if (mon_en) begin
      cur_t = {bus.freq_out, bus.note_on, bus.busy, bus.done, bus.cur_addr};
      if (cur_t !== prev_t) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change cyc=%0d got freq=%0d note=%b busy=%b done=%b addr=%0d",
                   cyc, cur_t[14:7], cur_t[6], cur_t[5], cur_t[4], cur_t[3:0]);
        end else begin
          e = exp_q.pop_front();
          if ({32'(cyc), cur_t} !== e) begin
            miscompares++;
            $display("FAIL output_change got cyc=%0d freq=%0d note=%b busy=%b done=%b addr=%0d, required cyc=%0d freq=%0d note=%b busy=%b done=%b addr=%0d",
                     cyc, cur_t[14:7], cur_t[6], cur_t[5], cur_t[4], cur_t[3:0],
                     e[46:15], e[14:7], e[6], e[5], e[4], e[3:0]);
          end
        end
        prev_t = cur_t;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic wr(input int a, input int p, input int d);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 4'(a);
    bus.wr_period = 8'(p);
    bus.wr_dur    = 8'(d);
    @(negedge clk);
    bus.wr_en     = 1'b0;
  endtask

  task automatic prog(input int a, input int p, input int d);
    wr(a, p, d);
    mem_p[a] = p;
    mem_d[a] = d;
  endtask

  task automatic launch(input int last, input bit lp);
    bus.start     = 1'b1;
    bus.last_addr = 4'(last);
    bus.loop      = lp;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int s, idx, g, last;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_period = '0; bus.wr_dur = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0; bus.last_addr = '0;
    m_last = mk(0, 1'b0, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("reset_freq", int'(bus.freq_out), 0);
    chk("reset_note_on", int'(bus.note_on), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_cur_addr", int'(bus.cur_addr), 0);
    chk("reset_state", int'(state_dbg), int'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);
    prev_t = {bus.freq_out, bus.note_on, bus.busy, bus.done, bus.cur_addr};
    mon_en = 1'b1;

    // single note
    prog(0, 50, 2);
    add_note(0); add_done(0);
    s = cyc + 1; commit(s, -1, '0); launch(0, 1'b0);
    drain("single");

    // rest then dur=0
    prog(0, 0, 1); prog(1, 30, 0);
    add_note(0); add_note(1); add_done(1);
    s = cyc + 1; commit(s, -1, '0); launch(1, 1'b0);
    drain("rest_dur0");

    // loop for three passes, then stop
    prog(0, 20, 1); prog(1, 40, 2);
    repeat (3) begin add_note(0); add_note(1); end
    s = cyc + 1; commit(s, 60, mk(0, 1'b0, 1'b0, 1'b0, 1)); launch(1, 1'b1);
    wait_until(s + 59);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0; bus.loop = 1'b0;
    drain("loop");

    // stop during PLAY of entry 3
    for (int a = 0; a < 4; a++) prog(a, 11 + a, 1);
    for (int a = 0; a < 4; a++) add_note(a);
    idx = fetch_idx[3];
    s = cyc + 1; commit(s, idx + 3, mk(0, 1'b0, 1'b0, 1'b0, 3)); launch(3, 1'b0);
    wait_until(s + idx + 2);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_freq", int'(bus.freq_out), 0);
    chk("stop_done", int'(bus.done), 0);
    drain("stop");

    // start and stop together: stays idle
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    chk("start_stop_state", int'(state_dbg), int'(ST_IDLE));
    chk("start_stop_busy", int'(bus.busy), 0);

    // rewrite entry 1 while entry 0 plays
    prog(0, 60, 2); prog(1, 10, 1);
    mem_p[1] = 77; mem_d[1] = 1;
    add_note(0); add_note(1); add_done(1);
    s = cyc + 1; commit(s, -1, '0); launch(1, 1'b0);
    wait_until(s + 3);
    wr(1, 77, 1);
    drain("write_during_play");

    // write entry 1 on the very edge that fetches it: old data plays
    prog(0, 25, 1); prog(1, 35, 1);
    add_note(0); add_note(1); add_done(1);
    idx = fetch_idx[1];
    s = cyc + 1; commit(s, -1, '0); launch(1, 1'b0);
    wait_until(s + idx);
    wr(1, 99, 3);
    drain("read_before_write");
    mem_p[1] = 99; mem_d[1] = 3;
    add_note(0); add_note(1); add_done(1);
    s = cyc + 1; commit(s, -1, '0); launch(1, 1'b0);
    drain("new_data");

    // reset during the gap of entry 1, then replay
    prog(0, 44, 1); prog(1, 55, 2); prog(2, 66, 1);
    add_note(0); add_note(1); add_note(2); add_done(2);
    g = fetch_idx[1] + 1 + 2 * TD;
    s = cyc + 1; commit(s, g + 1, mk(0, 1'b0, 1'b0, 1'b0, 0)); launch(2, 1'b0);
    wait_until(s + g);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_freq", int'(bus.freq_out), 0);
    chk("midreset_note_on", int'(bus.note_on), 0);
    chk("midreset_busy", int'(bus.busy), 0);
    chk("midreset_cur_addr", int'(bus.cur_addr), 0);
    chk("midreset_state", int'(state_dbg), int'(ST_IDLE));
    reset = 1'b0;
    drain("reset_gap");
    add_note(0); add_note(1); add_note(2); add_done(2);
    s = cyc + 1; commit(s, -1, '0); launch(2, 1'b0);
    drain("replay");

    // randomized programs
    for (int it = 0; it < 4; it++) begin
      last = $urandom_range(0, 5);
      for (int a = 0; a <= last; a++)
        prog(a, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255), $urandom_range(0, 3));
      for (int a = 0; a <= last; a++) add_note(a);
      add_done(last);
      s = cyc + 1; commit(s, -1, '0); launch(last, 1'b0);
      drain("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
